// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word plus the memory arbiter's state and
// operation encodings.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Arbiter FSM: idle, serving the data requester, serving the fetch requester.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DSERV = 2'd1,
    ISERV = 2'd2
  } arb_state_t;

  // Operation latched at a data grant; fetches are always reads.
  typedef enum logic {
    ARB_READ  = 1'b0,
    ARB_WRITE = 1'b1
  } arb_op_t;

  // Watchdog width, enough for a 255-cycle access limit.
  localparam int unsigned ARB_WDOG_W = 8;

  // Bits needed to hold a streak count in 0..max_streak.
  function automatic int unsigned streak_width(input int unsigned max_streak);
    return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Cycle counter with synchronous clear and count enable. tc_o is high while
// the count equals TERMINAL; the counter holds there until cleared.
module arb_watchdog #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TERMINAL = 254
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [WIDTH-1:0] count_q;

  // Count enabled cycles; clear has priority, saturate at the terminal value.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples values from before the clock edge.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && !tc_o) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign tc_o = (count_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported RAM between instruction fetch and the MEM stage.
// Data wins contention, but after MAX_DSTREAK consecutive data grants made
// while a fetch waits, the fetch gets the next grant. The granted address and
// store data are latched so the RAM side stays stable for the whole access.
// A watchdog ends any access that waits TIMEOUT cycles for ramready.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  // instruction requester
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  // data requester
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dhit,
  output logic [31:0] dload,
  // RAM side
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  // status
  output logic        err
);

  localparam int unsigned    SW         = streak_width(MAX_DSTREAK);
  localparam logic [SW-1:0]  STREAK_MAX = SW'(MAX_DSTREAK);

  arb_state_t    state_q;
  arb_op_t       op_q;
  logic [SW-1:0] dstreak_q;
  logic          ramren_q;
  logic          ramwen_q;
  word_t         ramaddr_q;
  word_t         ramstore_q;
  logic          ihit_q;
  logic          dhit_q;
  word_t         iload_q;
  word_t         dload_q;
  logic          err_q;

  logic d_req;
  logic in_idle;
  logic hit_out;
  logic streak_full;
  logic grant_d;
  logic grant_i;
  logic req_held;
  logic svc_abort;
  logic svc_done;
  logic svc_tmo;
  logic svc_exit;
  logic wdog_clr;
  logic wdog_tc;

  // ---------------------------------------------------------------------------
  // Grant decision, made only in IDLE. The cycle that carries a hit pulse is a
  // forced bubble: the requester just completed and its request line is still
  // up, so granting there would replay the same access.
  // ---------------------------------------------------------------------------
  assign d_req       = dREN | dWEN;
  assign in_idle     = (state_q == IDLE);
  assign hit_out     = ihit_q | dhit_q;
  assign streak_full = iREN && (dstreak_q == STREAK_MAX);
  assign grant_d     = in_idle && !hit_out && d_req && !streak_full;
  assign grant_i     = in_idle && !hit_out && iREN && !grant_d;

  // Whether the requester owning the current access still holds its request.
  // NOTE: the default assignment comes first so every path drives req_held;
  // a branch that skipped it would infer a latch.
  always_comb begin
    req_held = 1'b0;
    case (state_q)
      DSERV:   req_held = d_req;
      ISERV:   req_held = iREN;
      default: req_held = 1'b0;
    endcase
  end

  // Ways out of a service state. A dropped request (pipeline flush) wins over
  // a same-cycle ramready, and the RAM result is then discarded.
  assign svc_abort = !in_idle && !req_held;
  assign svc_done  = !in_idle && req_held && ramready;
  assign svc_tmo   = !in_idle && req_held && !ramready && wdog_tc;
  assign svc_exit  = svc_abort | svc_done | svc_tmo;

  // The watchdog sits at zero in IDLE and is cleared on the exit edge too, so
  // it restarts from zero on every state change.
  assign wdog_clr = in_idle | svc_exit;

  arb_watchdog #(
    .WIDTH    (ARB_WDOG_W),
    .TERMINAL (TIMEOUT - 1)
  ) u_wdog (
    .CLK   (CLK),
    .nRST  (nRST),
    .clr_i (wdog_clr),
    .en_i  (!in_idle),
    .tc_o  (wdog_tc)
  );

  // ---------------------------------------------------------------------------
  // Arbiter FSM with registered RAM enables, latched address/data, hit pulses
  // and load registers. Every register is reset because the whole output set
  // must read zero while nRST is low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      op_q       <= ARB_READ;
      dstreak_q  <= '0;
      ramren_q   <= 1'b0;
      ramwen_q   <= 1'b0;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
      ihit_q     <= 1'b0;
      dhit_q     <= 1'b0;
      iload_q    <= '0;
      dload_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      // hits are single-cycle pulses
      ihit_q <= 1'b0;
      dhit_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q    <= DSERV;
            ramaddr_q  <= daddr;
            ramstore_q <= dstore;
            // read+write together is illegal: perform the write, flag it
            op_q       <= dWEN ? ARB_WRITE : ARB_READ;
            ramwen_q   <= dWEN;
            ramren_q   <= !dWEN;
            if (dREN && dWEN) begin
              err_q <= 1'b1;
            end
            // only grants that make a fetch wait count toward the streak
            if (iREN && (dstreak_q < STREAK_MAX)) begin
              dstreak_q <= dstreak_q + 1'b1;
            end
          end else if (grant_i) begin
            state_q   <= ISERV;
            ramaddr_q <= iaddr;
            op_q      <= ARB_READ;
            ramren_q  <= 1'b1;
            ramwen_q  <= 1'b0;
            dstreak_q <= '0;
          end
        end

        DSERV, ISERV: begin
          if (svc_exit) begin
            state_q  <= IDLE;
            ramren_q <= 1'b0;
            ramwen_q <= 1'b0;
          end
          if (svc_done) begin
            if (state_q == DSERV) begin
              dhit_q <= 1'b1;
              // a write completes with dload left untouched
              if (op_q == ARB_READ) begin
                dload_q <= ramload;
              end
            end else begin
              ihit_q  <= 1'b1;
              iload_q <= ramload;
            end
          end
          if (svc_tmo) begin
            err_q <= 1'b1;
          end
        end

        default: begin
          state_q  <= IDLE;
          ramren_q <= 1'b0;
          ramwen_q <= 1'b0;
        end
      endcase
    end
  end

  assign ihit     = ihit_q;
  assign iload    = iload_q;
  assign dhit     = dhit_q;
  assign dload    = dload_q;
  assign ramREN   = ramren_q;
  assign ramWEN   = ramwen_q;
  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by a randomized run.
// A behavioural RAM answers accesses; a word-level scoreboard holds the
// expected memory contents and the arbitration rules.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int MAXD = 4;
  localparam int TMO  = 255;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic        ihit, dhit, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic [31:0] ramload = '0;
  logic        ramready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.MAX_DSTREAK(MAXD), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .err(err)
  );

  // ---------------- behavioural RAM ----------------
  word_t ram_mem[word_t];
  word_t ref_mem[word_t];
  bit    ram_rand  = 1'b0;   // random 0..3 extra wait cycles per access
  bit    ram_never = 1'b0;   // never answer
  int    wait_left = -1;     // -1 idle, -2 answered, >=0 cycles to go
  word_t exp_dload = '0;

  function automatic word_t init_word(input word_t a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic word_t ram_rd(input word_t a);
    return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
  endfunction

  function automatic word_t ref_rd(input word_t a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  always @(negedge CLK) begin
    ramready = 1'b0;
    ramload  = 32'($urandom);
    if (!(ramREN || ramWEN)) begin
      wait_left = -1;
    end else begin
      if (wait_left == -1) wait_left = ram_rand ? int'($urandom_range(0, 3)) : 0;
      if (wait_left == 0 && !ram_never) begin
        ramready  = 1'b1;
        wait_left = -2;
        if (ramWEN) ram_mem[ramaddr] = ramstore;
        else        ramload = ram_rd(ramaddr);
      end else if (wait_left > 0) begin
        wait_left--;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if ({ihit, dhit, ramREN, ramWEN, err} !== 5'b0) begin errors++; $display("FAIL reset_flags got=%b exp=00000", {ihit, dhit, ramREN, ramWEN, err}); end
    checks++; if (iload !== 32'h0) begin errors++; $display("FAIL reset_iload got=%h exp=0", iload); end
    checks++; if (dload !== 32'h0) begin errors++; $display("FAIL reset_dload got=%h exp=0", dload); end
    checks++; if (ramaddr !== 32'h0) begin errors++; $display("FAIL reset_ramaddr got=%h exp=0", ramaddr); end
    checks++; if (ramstore !== 32'h0) begin errors++; $display("FAIL reset_ramstore got=%h exp=0", ramstore); end
    nRST = 1'b1;
    tick();
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL idle_no_req_ramREN got=%b exp=0", ramREN); end
  endtask

  task automatic test_lone_fetch();
    ram_mem[32'h40] = 32'h8C01_0004;
    iREN = 1'b1; iaddr = 32'h40;
    tick();
    checks++; if ({ramREN, ramWEN, ihit} !== 3'b100) begin errors++; $display("FAIL fetch_iserv_enables got=%b exp=100", {ramREN, ramWEN, ihit}); end
    checks++; if (ramaddr !== 32'h40) begin errors++; $display("FAIL fetch_ramaddr got=%h exp=40", ramaddr); end
    tick();
    checks++; if ({ihit, ramREN} !== 2'b10) begin errors++; $display("FAIL fetch_ihit got=%b exp=10", {ihit, ramREN}); end
    checks++; if (iload !== 32'h8C01_0004) begin errors++; $display("FAIL fetch_iload got=%h exp=8c010004", iload); end
    iREN = 1'b0;
    tick();
    checks++; if (ihit !== 1'b0 || iload !== 32'h8C01_0004) begin errors++; $display("FAIL fetch_hold got=%b/%h exp=0/8c010004", ihit, iload); end
  endtask

  task automatic test_contention();
    ram_mem[32'h100] = 32'h1111_2222;
    iREN = 1'b1; iaddr = 32'h40;
    dREN = 1'b1; daddr = 32'h100;
    tick();
    checks++; if (ramaddr !== 32'h100 || ramREN !== 1'b1) begin errors++; $display("FAIL contend_data_first got=%h/%b exp=100/1", ramaddr, ramREN); end
    tick();
    checks++; if ({dhit, ihit} !== 2'b10) begin errors++; $display("FAIL contend_dhit got=%b exp=10", {dhit, ihit}); end
    checks++; if (dload !== 32'h1111_2222) begin errors++; $display("FAIL contend_dload got=%h exp=11112222", dload); end
    exp_dload = 32'h1111_2222;
    dREN = 1'b0;
    tick();
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL contend_bubble got=%b exp=0", ramREN); end
    tick();
    checks++; if (ramaddr !== 32'h40 || ramREN !== 1'b1) begin errors++; $display("FAIL contend_iserv got=%h/%b exp=40/1", ramaddr, ramREN); end
    tick();
    checks++; if (ihit !== 1'b1 || iload !== 32'h8C01_0004) begin errors++; $display("FAIL contend_ihit got=%b/%h exp=1/8c010004", ihit, iload); end
    iREN = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    int seq[$];
    logic [5:0] got;
    ram_mem[32'h300] = 32'hCAFE_0300;
    iREN = 1'b1; iaddr = 32'h40;
    dREN = 1'b1; daddr = 32'h300;
    for (int c = 0; c < 100 && seq.size() < 6; c++) begin
      tick();
      if (dhit) seq.push_back(0);
      if (ihit) seq.push_back(1);
    end
    iREN = 1'b0; dREN = 1'b0;
    checks++; if (seq.size() != 6) begin errors++; $display("FAIL starve_hit_count got=%0d exp=6", seq.size()); end
    got = '0;
    for (int k = 0; k < seq.size() && k < 6; k++) got[k] = seq[k][0];
    checks++; if (got !== 6'b010000) begin errors++; $display("FAIL starve_order got=%b exp=010000 (bit0 first, 1=ihit)", got); end
    checks++; if (dload !== 32'hCAFE_0300) begin errors++; $display("FAIL starve_dload got=%h exp=cafe0300", dload); end
    exp_dload = 32'hCAFE_0300;
    repeat (4) tick();
  endtask

  task automatic test_write();
    dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEAD_BEEF;
    tick();
    checks++; if ({ramREN, ramWEN} !== 2'b01) begin errors++; $display("FAIL write_enables got=%b exp=01", {ramREN, ramWEN}); end
    checks++; if (ramaddr !== 32'h200 || ramstore !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_latch got=%h/%h exp=200/deadbeef", ramaddr, ramstore); end
    tick();
    checks++; if (dhit !== 1'b1) begin errors++; $display("FAIL write_dhit got=%b exp=1", dhit); end
    checks++; if (dload !== exp_dload) begin errors++; $display("FAIL write_dload_kept got=%h exp=%h", dload, exp_dload); end
    dWEN = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    bit seen = 1'b0;
    ram_never = 1'b1;
    iREN = 1'b1; iaddr = 32'h80;
    tick();
    checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL abort_granted got=%b exp=1", ramREN); end
    repeat (3) tick();
    iREN = 1'b0;
    tick();
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL abort_enables got=%b exp=0", ramREN); end
    repeat (4) begin
      if (ihit) seen = 1'b1;
      tick();
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_ihit got=%b exp=0", seen); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL abort_err got=%b exp=0", err); end
    ram_never = 1'b0;
  endtask

  task automatic test_timeout();
    int  high = 0;
    bit  saw  = 1'b0;
    int  lat  = 0;
    ram_never = 1'b1;
    dREN = 1'b1; daddr = 32'h400;
    tick();
    for (int c = 0; c < 400; c++) begin
      if (dhit) saw = 1'b1;
      if (!ramREN) break;
      high++;
      tick();
    end
    dREN = 1'b0;
    checks++; if (high != TMO) begin errors++; $display("FAIL timeout_cycles got=%0d exp=%0d", high, TMO); end
    checks++; if (err !== 1'b1 || saw !== 1'b0) begin errors++; $display("FAIL timeout_err got=err%b/hit%b exp=err1/hit0", err, saw); end
    ram_never = 1'b0;
    tick();
    iREN = 1'b1; iaddr = 32'h40;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (ihit) begin lat = c; break; end
    end
    iREN = 1'b0;
    checks++; if (lat != 2) begin errors++; $display("FAIL post_timeout_fetch got=%0d exp=2", lat); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat = 0;
    ram_never = 1'b1;
    ram_mem[32'h500] = 32'h0BAD_F00D;
    dREN = 1'b1; daddr = 32'h500;
    tick();
    checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL rstmid_granted got=%b exp=1", ramREN); end
    #2;
    nRST = 1'b0;
    #1;
    checks++; if ({ihit, dhit, ramREN, ramWEN, err} !== 5'b0) begin errors++; $display("FAIL rstmid_flags got=%b exp=00000", {ihit, dhit, ramREN, ramWEN, err}); end
    checks++; if ({iload, dload, ramaddr, ramstore} !== 128'h0) begin errors++; $display("FAIL rstmid_words got=%h exp=0", {iload, dload, ramaddr, ramstore}); end
    exp_dload = '0;
    ram_never = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (dhit) begin lat = c; break; end
    end
    dREN = 1'b0;
    checks++; if (lat != 2) begin errors++; $display("FAIL rstmid_regrant got=%0d exp=2", lat); end
    checks++; if (dload !== 32'h0BAD_F00D) begin errors++; $display("FAIL rstmid_dload got=%h exp=0badf00d", dload); end
    exp_dload = 32'h0BAD_F00D;
    tick();
  endtask

  task automatic test_protocol_err();
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h600; dstore = 32'h1234_5678;
    tick();
    checks++; if ({ramREN, ramWEN, err} !== 3'b011) begin errors++; $display("FAIL both_req_write got=%b exp=011", {ramREN, ramWEN, err}); end
    tick();
    checks++; if (dhit !== 1'b1 || dload !== exp_dload) begin errors++; $display("FAIL both_req_dhit got=%b/%h exp=1/%h", dhit, dload, exp_dload); end
    dREN = 1'b0; dWEN = 1'b0;
    tick();
  endtask

  // ---------------- randomized run against the scoreboard ----------------
  function automatic word_t rand_addr();
    return 32'h1000 + 32'($urandom_range(0, 31) << 2);
  endfunction

  task automatic test_random();
    bit    i_pend = 0, d_pend = 0, d_write = 0;
    word_t i_addr = '0, d_addr = '0, d_data = '0;
    int    i_age = 0, d_age = 0, d_while_i = 0;
    ram_rand = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (ihit) begin
        checks++;
        if (!i_pend) begin errors++; $display("FAIL rnd_spurious_ihit cyc=%0d got=1 exp=0", cyc); end
        else begin
          checks++; if (iload !== ref_rd(i_addr)) begin errors++; $display("FAIL rnd_iload addr=%h got=%h exp=%h", i_addr, iload, ref_rd(i_addr)); end
          checks++; if (d_while_i > MAXD + 1) begin errors++; $display("FAIL rnd_starvation got=%0d exp<=%0d", d_while_i, MAXD + 1); end
          i_pend = 0; iREN = 1'b0;
        end
      end
      if (dhit) begin
        checks++;
        if (!d_pend) begin errors++; $display("FAIL rnd_spurious_dhit cyc=%0d got=1 exp=0", cyc); end
        else begin
          if (d_write) begin
            checks++; if (dload !== exp_dload) begin errors++; $display("FAIL rnd_dload_kept got=%h exp=%h", dload, exp_dload); end
            ref_mem[d_addr] = d_data;
          end else begin
            checks++; if (dload !== ref_rd(d_addr)) begin errors++; $display("FAIL rnd_dload addr=%h got=%h exp=%h", d_addr, dload, ref_rd(d_addr)); end
            exp_dload = ref_rd(d_addr);
          end
          if (i_pend) d_while_i++;
          d_pend = 0; dREN = 1'b0; dWEN = 1'b0;
        end
      end
      if (ramWEN) begin
        checks++;
        if (!(d_pend && d_write && ramaddr === d_addr && ramstore === d_data)) begin
          errors++; $display("FAIL rnd_write_side got=%h/%h exp=%h/%h", ramaddr, ramstore, d_addr, d_data);
        end
      end
      if (i_pend) i_age++;
      if (d_pend) d_age++;
      if (i_pend && i_age > 200) begin checks++; errors++; $display("FAIL rnd_i_never_served got=%0d exp<=200", i_age); i_pend = 0; iREN = 1'b0; end
      if (d_pend && d_age > 200) begin checks++; errors++; $display("FAIL rnd_d_never_served got=%0d exp<=200", d_age); d_pend = 0; dREN = 1'b0; dWEN = 1'b0; end
      if (cyc < 2800 && !i_pend && $urandom_range(0, 3) == 0) begin
        i_pend = 1; i_age = 0; d_while_i = 0;
        i_addr = rand_addr();
        iREN = 1'b1; iaddr = i_addr;
      end
      if (cyc < 2800 && !d_pend && $urandom_range(0, 2) != 0) begin
        d_pend = 1; d_age = 0;
        d_write = ($urandom_range(0, 2) == 0);
        d_addr = rand_addr();
        d_data = 32'($urandom);
        dREN = !d_write; dWEN = d_write;
        daddr = d_addr; dstore = d_data;
      end
    end
    checks++; if (i_pend || d_pend) begin errors++; $display("FAIL rnd_drain got=i%b/d%b exp=i0/d0", i_pend, d_pend); end
    ram_rand = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_contention();
    test_starvation();
    test_write();
    test_abort();
    test_timeout();
    test_reset_mid();
    test_protocol_err();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit got=running exp=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates a single-ported shared RAM between the instruction-fetch requester and the data (MEM-stage) requester of the 5-stage pipeline.
- Grants one requester at a time and latches its address and store data so RAM-side signals stay stable for the whole access.
- Returns ihit/dhit pulses plus load data to the datapath.
- Data has priority, because a stalled MEM stage blocks the whole pipe. A streak limit prevents the data side from starving fetch. A watchdog flags a hung RAM.

Parameters:
- MAX_DSTREAK, 4: consecutive data grants allowed while an instruction request is pending; the next grant then goes to instruction.
- TIMEOUT, 255: cycles a granted access may wait for ramready before abort and error.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  1  instruction read request (level, held until ihit)
- iaddr  in  32  instruction address
- dREN  in  1  data read request (level, held until dhit)
- dWEN  in  1  data write request (level, held until dhit)
- daddr  in  32  data address
- dstore  in  32  data write value
- ihit  out  1  one-cycle pulse: instruction access done
- iload  out  32  fetched instruction, valid when ihit=1
- dhit  out  1  one-cycle pulse: data access done
- dload  out  32  loaded word, valid when dhit=1 on a read
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address (latched)
- ramstore  out  32  RAM write data (latched)
- ramload  in  32  RAM read data
- ramready  in  1  RAM access complete, one cycle
- err  out  1  sticky error flag

Behaviour:
- Reset: state=IDLE. All outputs 0: ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err. dstreak=0, wdog=0.
- States:
  - IDLE: no RAM enables asserted.
  - DSERV: ramREN or ramWEN asserted per the latched operation.
  - ISERV: ramREN asserted.
- IDLE grant, evaluated each cycle:
  - If (dREN|dWEN) and not (iREN and dstreak==MAX_DSTREAK): go to DSERV. Latch ramaddr=daddr, ramstore=dstore, op=write if dWEN else read. dstreak increments only when iREN=1, saturating at MAX_DSTREAK.
  - Else if iREN: go to ISERV. Latch ramaddr=iaddr. dstreak=0.
  - Else stay in IDLE.
- dREN=1 and dWEN=1 together is a protocol error: treat as write and set err.
- Service states:
  - wdog counts cycles in state. Enables are driven from the latched op.
  - On ramready=1: go to IDLE next cycle and pulse the matching hit in that same next cycle. iload/dload are registered from ramload and hold their value until the next hit. Writes pulse dhit with dload unchanged.
- Latency: with a 1-cycle RAM, grant at edge N, ramready in cycle N, hit visible in cycle N+1. At least one IDLE bubble separates back-to-back grants, so the best-case sustained rate is 1 access per 3 cycles.
- Abort: if the granted request drops (flush) before ramready, go to IDLE next cycle with no hit and enables deasserted. The RAM result is discarded.
- Timeout: wdog==TIMEOUT-1 without ramready → IDLE, err=1, no hit.
- err: sticky until reset.
- ramready in IDLE: ignored.
- Reset mid-access: immediate return to IDLE with all outputs 0. The requester must re-issue.
- wdog is 8 bits wide, sized for TIMEOUT; it clears on every state change.

Decomposition:
- Shared package (cpu_types_pkg): word_t (already present), arb_state_t enum {IDLE, DSERV, ISERV}, arb_op_t {ARB_READ, ARB_WRITE}.
- One natural sub-module, arb_watchdog: a counter with clear/enable and a terminal-count output, reused for the timeout.
- The grant logic and FSM stay in mem_arbiter.

Test Plan:
- Lone fetch: iREN=1, iaddr=0x40, RAM returns 0x8C010004 after 1 cycle → ihit pulses 1 cycle later with iload=0x8C010004; ramREN high only in ISERV.
- Contention: iREN=1 and dREN=1 (daddr=0x100) in the same cycle → DSERV granted first, dhit occurs, then ISERV for 0x40.
- Starvation: iREN held, dREN re-asserted immediately after every dhit → exactly 4 dhits, then 1 ihit, then data resumes.
- Write: dWEN=1, daddr=0x200, dstore=0xDEADBEEF → ramWEN=1, ramaddr=0x200, ramstore=0xDEADBEEF, then dhit pulse; dload unchanged.
- Abort/timeout: drop iREN mid-ISERV → IDLE with no ihit, err=0. Separately, hold ramready=0 for 255 cycles → IDLE with err=1 stuck until nRST.
- Reset in DSERV: assert nRST=0 → all outputs 0 asynchronously; after release, state=IDLE and the held dREN is re-granted.
